// File: rtl/smpl_iter_ctrl.sv
// Sample iterator controller: takes one triangle and its bounding box from
// the bbox stage and walks the box in subsample steps (raster order), handing
// one sample per cycle to sample test while holding bbox off with halt.
//
// Flat port layouts:
//   box_R13S    : {ur.y, ur.x, ll.y, ll.x}, each SIGFIG bits, signed
//   sample_R14S : {y, x}, each SIGFIG bits, signed
//
// Handshake: a sample is presented while validSamp_R14H = 1 and is consumed
// on every rising edge where stall_R14H = 0; while stalled every output holds.
module smpl_iter_ctrl #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SIGFIG*VERTS*AXIS-1:0]    tri_R13S,
    input  logic [SIGFIG*COLORS-1:0]        color_R13U,
    input  logic [SIGFIG*4-1:0]             box_R13S,
    input  logic                            validTri_R13H,
    input  logic [3:0]                      subSample_RnnnnU,
    input  logic                            stall_R14H,
    output logic                            halt_RnnnnH,
    output logic [SIGFIG*VERTS*AXIS-1:0]    tri_R14S,
    output logic [SIGFIG*COLORS-1:0]        color_R14U,
    output logic [SIGFIG*2-1:0]             sample_R14S,
    output logic                            validSamp_R14H,
    output logic                            triDone_R14H,
    output logic [31:0]                     smplCnt_R14U,
    output logic                            state_dbg_o
);

    localparam int S = SIGFIG;
    localparam int W = SIGFIG + 1;

    typedef enum logic {
        WAIT = 1'b0,
        TEST = 1'b1
    } state_t;

    state_t                           state_q;
    logic                             halt_q;
    logic                             valid_q;
    logic [SIGFIG*VERTS*AXIS-1:0]     tri_q;
    logic [SIGFIG*COLORS-1:0]         color_q;
    logic signed [S-1:0]              llx_q, lly_q, urx_q, ury_q;
    logic signed [S-1:0]              x_q, y_q;
    logic [31:0]                      cnt_q;

    logic signed [S-1:0]              x_d, y_d;
    logic [31:0]                      cnt_d;

    logic signed [S-1:0]              in_llx, in_lly, in_urx, in_ury;
    logic                             box_ok;
    logic [1:0]                       ss_w_lg2;
    logic signed [W-1:0]              step_w;
    logic signed [W-1:0]              x_ext, y_ext, urx_ext, ury_ext;
    logic signed [W-1:0]              nx_w, ny_w;
    logic                             can_x, can_y, last;

    assign in_llx = box_R13S[S-1:0];
    assign in_lly = box_R13S[2*S-1:S];
    assign in_urx = box_R13S[3*S-1:2*S];
    assign in_ury = box_R13S[4*S-1:3*S];
    assign box_ok = (in_llx <= in_urx) && (in_lly <= in_ury);

    // Decode the one-hot subsample mode into the grid step (finest mode wins).
    always_comb begin
        ss_w_lg2 = 2'd0;
        if (subSample_RnnnnU[0])      ss_w_lg2 = 2'd3;
        else if (subSample_RnnnnU[1]) ss_w_lg2 = 2'd2;
        else if (subSample_RnnnnU[2]) ss_w_lg2 = 2'd1;
        step_w = {{(W-1){1'b0}}, 1'b1} << (RADIX - int'(ss_w_lg2));
    end

    // Raster advance: one extra bit so a step past the top coordinate cannot wrap.
    always_comb begin
        x_ext   = {x_q[S-1], x_q};
        y_ext   = {y_q[S-1], y_q};
        urx_ext = {urx_q[S-1], urx_q};
        ury_ext = {ury_q[S-1], ury_q};
        nx_w    = x_ext + step_w;
        ny_w    = y_ext + step_w;
        can_x   = (nx_w <= urx_ext);
        can_y   = (ny_w <= ury_ext);
        last    = !can_x && !can_y;
        x_d     = x_q;
        y_d     = y_q;
        if (can_x) begin
            x_d = nx_w[S-1:0];
        end else begin
            x_d = llx_q;
            y_d = ny_w[S-1:0];
        end
        cnt_d   = cnt_q + 32'd1;
    end

    // Controller FSM: latch a well-formed triangle in WAIT, walk it in TEST.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WAIT;
            halt_q  <= 1'b0;
            valid_q <= 1'b0;
            tri_q   <= '0;
            color_q <= '0;
            llx_q   <= '0;
            lly_q   <= '0;
            urx_q   <= '0;
            ury_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (validTri_R13H && box_ok) begin
                        tri_q   <= tri_R13S;
                        color_q <= color_R13U;
                        llx_q   <= in_llx;
                        lly_q   <= in_lly;
                        urx_q   <= in_urx;
                        ury_q   <= in_ury;
                        x_q     <= in_llx;
                        y_q     <= in_lly;
                        cnt_q   <= 32'd1;
                        halt_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= TEST;
                    end
                end
                TEST: begin
                    if (!stall_R14H) begin
                        if (last) begin
                            halt_q  <= 1'b0;
                            valid_q <= 1'b0;
                            state_q <= WAIT;
                        end else begin
                            x_q   <= x_d;
                            y_q   <= y_d;
                            cnt_q <= cnt_d;
                        end
                    end
                end
                default: state_q <= WAIT;
            endcase
        end
    end

    assign halt_RnnnnH    = halt_q;
    assign validSamp_R14H = valid_q;
    assign triDone_R14H   = valid_q && last;
    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S    = {y_q, x_q};
    assign smplCnt_R14U   = cnt_q;
    assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_smpl_iter_ctrl.sv
// Bench for smpl_iter_ctrl: table of boxes walked through a raster-order
// reference model feeding an expected-sample queue, plus hand sequences for
// back-to-back triangles and asynchronous reset mid-walk.
module tb_smpl_iter_ctrl;

    localparam int S  = 24;
    localparam int TW = S * 9;
    localparam int CW = S * 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [TW-1:0]   tri_R13S;
    logic [CW-1:0]   color_R13U;
    logic [S*4-1:0]  box_R13S;
    logic            validTri_R13H;
    logic [3:0]      subSample_RnnnnU;
    logic            stall_R14H;
    logic            halt_RnnnnH;
    logic [TW-1:0]   tri_R14S;
    logic [CW-1:0]   color_R14U;
    logic [S*2-1:0]  sample_R14S;
    logic            validSamp_R14H;
    logic            triDone_R14H;
    logic [31:0]     smplCnt_R14U;
    logic            state_dbg_o;

    smpl_iter_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_R13S),
        .color_R13U       (color_R13U),
        .box_R13S         (box_R13S),
        .validTri_R13H    (validTri_R13H),
        .subSample_RnnnnU (subSample_RnnnnU),
        .stall_R14H       (stall_R14H),
        .halt_RnnnnH      (halt_RnnnnH),
        .tri_R14S         (tri_R14S),
        .color_R14U       (color_R14U),
        .sample_R14S      (sample_R14S),
        .validSamp_R14H   (validSamp_R14H),
        .triDone_R14H     (triDone_R14H),
        .smplCnt_R14U     (smplCnt_R14U),
        .state_dbg_o      (state_dbg_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;

    // expected entry: {done, cnt[31:0], y[23:0], x[23:0]}
    logic [80:0] exp_q[$];
    logic [80:0] mon_e;

    typedef struct {
        longint   llx;
        longint   lly;
        longint   urx;
        longint   ury;
        logic [3:0] ss;
        int       mode;   // 0 no stall, 1 random stall, 2 stall 3 cycles on (2048,0)
        int       n;      // hand-derived sample count
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: raster walk in 64-bit arithmetic, pushed to the queue.
    task automatic push_walk(input longint llx, input longint lly, input longint urx,
                             input longint ury, input logic [3:0] ss);
        longint step;
        int     lg2;
        int     cnt;
        int     first;
        lg2 = 0;
        if (ss[0])      lg2 = 3;
        else if (ss[1]) lg2 = 2;
        else if (ss[2]) lg2 = 1;
        step  = longint'(1) << (10 - lg2);
        cnt   = 0;
        first = exp_q.size();
        if (llx <= urx && lly <= ury) begin
            for (longint y = lly; y <= ury; y += step) begin
                for (longint x = llx; x <= urx; x += step) begin
                    cnt++;
                    exp_q.push_back({1'b0, 32'(cnt), 24'(y), 24'(x)});
                end
            end
            exp_q[exp_q.size()-1][80] = 1'b1;
        end
        if (first > exp_q.size()) $display("model queue shrank");
    endtask

    task automatic set_inputs(input longint llx, input longint lly, input longint urx,
                              input longint ury, input logic [3:0] ss);
        for (int i = 0; i < 9; i++) tri_R13S[i*S +: S] = 24'($urandom);
        for (int i = 0; i < 3; i++) color_R13U[i*S +: S] = 24'($urandom);
        box_R13S         = {24'(ury), 24'(urx), 24'(lly), 24'(llx)};
        subSample_RnnnnU = ss;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare every accepted sample against the queue head.
    always @(negedge clk) begin
        if (rst && validSamp_R14H && !stall_R14H) begin
            acc_cnt++;
            chk("sample_available", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("sample_x", $signed(sample_R14S[S-1:0]), $signed(mon_e[23:0]));
                chk("sample_y", $signed(sample_R14S[2*S-1:S]), $signed(mon_e[47:24]));
                chk("smpl_cnt", smplCnt_R14U, mon_e[79:48]);
                chk("tri_done", triDone_R14H, mon_e[80]);
            end
        end
    end

    // Driver: present one triangle and walk it to completion.
    task automatic run_vec(input vec_t v);
        logic [TW-1:0] tri_sent;
        logic [CW-1:0] col_sent;
        int cyc, done, halt_c, stall_c, st_run, seen_h, seen_v;
        push_walk(v.llx, v.lly, v.urx, v.ury, v.ss);
        acc_cnt = 0;
        set_inputs(v.llx, v.lly, v.urx, v.ury, v.ss);
        tri_sent = tri_R13S;
        col_sent = color_R13U;
        validTri_R13H = 1'b1;
        stall_R14H    = 1'b0;
        tick();
        validTri_R13H = 1'b0;
        if (v.n == 0) begin
            seen_h = 0;
            seen_v = 0;
            for (int i = 0; i < 4; i++) begin
                seen_h += int'(halt_RnnnnH);
                seen_v += int'(validSamp_R14H);
                tick();
            end
            chk("malformed_halt", seen_h, 0);
            chk("malformed_valid", seen_v, 0);
            chk("malformed_accepted", acc_cnt, 0);
        end else begin
            chk("first_latency", validSamp_R14H, 1);
            chk("tri_latched", (tri_R14S == tri_sent) ? 1 : 0, 1);
            chk("color_latched", (color_R14U == col_sent) ? 1 : 0, 1);
            cyc = 0; done = 0; halt_c = 0; stall_c = 0; st_run = 0;
            while (!done && cyc < 2000) begin
                halt_c += int'(halt_RnnnnH);
                stall_R14H = 1'b0;
                if (v.mode == 1) begin
                    stall_R14H = ($urandom_range(0, 2) == 0);
                end else if (v.mode == 2) begin
                    if (validSamp_R14H && sample_R14S == {24'd0, 24'd2048} && st_run < 3) begin
                        stall_R14H = 1'b1;
                        st_run++;
                        chk("stall_hold_cnt", smplCnt_R14U, 3);
                        chk("stall_hold_done", triDone_R14H, 0);
                    end
                end
                if (stall_R14H && validSamp_R14H) stall_c++;
                if (validSamp_R14H && triDone_R14H && !stall_R14H) done = 1;
                tick();
                cyc++;
            end
            stall_R14H = 1'b0;
            chk("tri_finished", done, 1);
            chk("accepted_count", acc_cnt, v.n);
            chk("halt_cycles", halt_c, v.n + stall_c);
            chk("halt_drop", halt_RnnnnH, 0);
            chk("valid_drop", validSamp_R14H, 0);
            chk("state_wait", state_dbg_o, 0);
            if (v.mode == 2) chk("stall_cycles", stall_c, 3);
        end
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{0, 0, 2048, 1024, 4'b1000, 0, 6};
        vecs[1] = '{0, 0, 1024, 128, 4'b0001, 0, 18};
        vecs[2] = '{0, 0, 2048, 1024, 4'b1000, 2, 6};
        vecs[3] = '{512, 512, 512, 512, 4'b0100, 0, 1};
        vecs[4] = '{2048, 0, 1024, 1024, 4'b1000, 0, 0};
        vecs[5] = '{-1024, -512, 512, 512, 4'b0010, 1, 35};
        vecs[6] = '{8388000, 8388000, 8388607, 8388607, 4'b1000, 0, 1};
        vecs[7] = '{100, 0, 400, 0, 4'b0001, 0, 3};

        rst = 1'b1;
        tri_R13S = '0;
        color_R13U = '0;
        box_R13S = '0;
        validTri_R13H = 1'b0;
        subSample_RnnnnU = 4'b1000;
        stall_R14H = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rst_halt", halt_RnnnnH, 0);
        chk("rst_valid", validSamp_R14H, 0);
        chk("rst_done", triDone_R14H, 0);
        chk("rst_cnt", smplCnt_R14U, 0);
        chk("rst_sample", sample_R14S, 0);
        chk("rst_state", state_dbg_o, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // back-to-back with validTri held high; second triangle presented while busy
        begin
            logic [TW-1:0] t1, t2;
            int cyc;
            push_walk(0, 0, 1024, 0, 4'b1000);
            push_walk(512, 512, 512, 512, 4'b1000);
            set_inputs(0, 0, 1024, 0, 4'b1000);
            t1 = tri_R13S;
            validTri_R13H = 1'b1;
            tick();
            set_inputs(512, 512, 512, 512, 4'b1000);
            t2 = tri_R13S;
            chk("b2b_busy_tri_held", (tri_R14S == t1) ? 1 : 0, 1);
            chk("b2b_first_x", $signed(sample_R14S[S-1:0]), 0);
            cyc = 0;
            while (!triDone_R14H && cyc < 50) begin
                tick();
                cyc++;
            end
            chk("b2b_first_done_seen", triDone_R14H, 1);
            chk("b2b_busy_tri_still", (tri_R14S == t1) ? 1 : 0, 1);
            tick();
            chk("b2b_gap_valid", validSamp_R14H, 0);
            chk("b2b_gap_halt", halt_RnnnnH, 0);
            tick();
            validTri_R13H = 1'b0;
            chk("b2b_second_valid", validSamp_R14H, 1);
            chk("b2b_second_tri", (tri_R14S == t2) ? 1 : 0, 1);
            chk("b2b_second_x", $signed(sample_R14S[S-1:0]), 512);
            tick();
            chk("b2b_second_end", validSamp_R14H, 0);
            chk("b2b_queue_empty", exp_q.size(), 0);
        end

        // asynchronous reset while the 3rd sample is presented
        begin
            int cyc;
            push_walk(0, 0, 2048, 1024, 4'b1000);
            set_inputs(0, 0, 2048, 1024, 4'b1000);
            validTri_R13H = 1'b1;
            tick();
            validTri_R13H = 1'b0;
            cyc = 0;
            while (smplCnt_R14U != 32'd3 && cyc < 20) begin
                tick();
                cyc++;
            end
            chk("rst_mid_reached", smplCnt_R14U, 3);
            #2 rst = 1'b0;
            #1;
            chk("rst_mid_halt", halt_RnnnnH, 0);
            chk("rst_mid_valid", validSamp_R14H, 0);
            chk("rst_mid_done", triDone_R14H, 0);
            chk("rst_mid_cnt", smplCnt_R14U, 0);
            chk("rst_mid_sample", sample_R14S, 0);
            chk("rst_mid_tri", (tri_R14S == '0) ? 1 : 0, 1);
            chk("rst_mid_state", state_dbg_o, 0);
            exp_q.delete();
            tick();
            rst = 1'b1;
            tick();
            chk("rst_mid_idle", validSamp_R14H, 0);
            run_vec(vecs[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
